// File: rtl/fpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_types_pkg
//  Description : Shared types, OP-FP funct5 codes and decode helpers for the
//                FP dispatch stage.
//                - dispatch_state_t     : issue FSM states
//                - fpu_dispatch_entry_t : one buffered op with its operands
//                - is_legal_fp_op()     : decoder select/funct5 legality
//                - is_long_fp_op()      : FDIV/FSQRT detection
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_types_pkg;

  // Operand width carried in a dispatch entry (half precision in x-regs).
  localparam int unsigned c_FLEN = 16;

  // Decoder select encodings
  localparam logic [2:0] c_SEL_OP_FP  = 3'd0;
  localparam logic [2:0] c_SEL_FMADD  = 3'd1;
  localparam logic [2:0] c_SEL_FMSUB  = 3'd2;
  localparam logic [2:0] c_SEL_FNMADD = 3'd3;
  localparam logic [2:0] c_SEL_FNMSUB = 3'd4;

  // OP-FP funct5 codes accepted by the execute units
  localparam logic [4:0] FUNCT5_FADD    = 5'b00000;
  localparam logic [4:0] FUNCT5_FSUB    = 5'b00001;
  localparam logic [4:0] FUNCT5_FMUL    = 5'b00010;
  localparam logic [4:0] FUNCT5_FDIV    = 5'b00011;
  localparam logic [4:0] FUNCT5_FSQRT   = 5'b01011;
  localparam logic [4:0] FUNCT5_FSGNJ   = 5'b00100;
  localparam logic [4:0] FUNCT5_FMINMAX = 5'b00101;
  localparam logic [4:0] FUNCT5_FCVT_FF = 5'b01000;
  localparam logic [4:0] FUNCT5_FCMP    = 5'b10100;
  localparam logic [4:0] FUNCT5_FCVT_WH = 5'b11000;
  localparam logic [4:0] FUNCT5_FCVT_HW = 5'b11010;
  localparam logic [4:0] FUNCT5_FCLASS  = 5'b11100;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LONG = 1'b1
  } dispatch_state_t;

  typedef struct packed {
    logic [2:0]        select;
    logic [4:0]        op;
    logic [2:0]        rm;
    logic [c_FLEN-1:0] rs1;
    logic [c_FLEN-1:0] rs2;
    logic [c_FLEN-1:0] rs3;
    logic [4:0]        rd;
  } fpu_dispatch_entry_t;

  // Fused ops are always legal; OP-FP is legal only for the listed funct5.
  function automatic logic is_legal_fp_op(input logic [2:0] sel, input logic [4:0] op);
    logic w_legal;
    w_legal = 1'b0;
    case (sel)
      c_SEL_OP_FP: begin
        case (op)
          FUNCT5_FADD, FUNCT5_FSUB, FUNCT5_FMUL, FUNCT5_FDIV, FUNCT5_FSQRT,
          FUNCT5_FSGNJ, FUNCT5_FMINMAX, FUNCT5_FCVT_FF, FUNCT5_FCMP,
          FUNCT5_FCVT_WH, FUNCT5_FCVT_HW, FUNCT5_FCLASS: w_legal = 1'b1;
          default:                                       w_legal = 1'b0;
        endcase
      end
      c_SEL_FMADD, c_SEL_FMSUB, c_SEL_FNMADD, c_SEL_FNMSUB: w_legal = 1'b1;
      default:                                              w_legal = 1'b0;
    endcase
    return w_legal;
  endfunction

  function automatic logic is_long_fp_op(input logic [2:0] sel, input logic [4:0] op);
    return (sel == c_SEL_OP_FP) && ((op == FUNCT5_FDIV) || (op == FUNCT5_FSQRT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_dispatch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_dispatch_fifo
//  Description : Synchronous FIFO of dispatch entries with flush.
//  Ports       : CLK, nRST (async active-low)
//                i_flush     - empties the FIFO next cycle, overrides push/pop
//                i_push      - write i_push_data (ignored when full)
//                i_pop       - drop head entry (ignored when empty)
//                o_head_data - head entry storage
//                o_count     - entries held (0..DEPTH)
//                o_empty / o_full
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_dispatch_fifo
  import fpu_types_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = fpu_dispatch_entry_t
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  ENTRY_T                   i_push_data,
  input  logic                     i_pop,
  output ENTRY_T                   o_head_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int              c_AW         = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL_COUNT = (c_AW + 1)'(DEPTH);

  ENTRY_T          r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == c_FULL_COUNT);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reads are only meaningful while non-empty.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fpu_dispatch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_dispatch_stage
//  Description : Buffers decoded Zhinx FP ops, drops illegal OP-FP codes and
//                issues ops in order to execute. After FDIV/FSQRT is issued,
//                further issue waits for long_done.
//  Ports       : CLK, nRST (async active-low), flush (sync)
//                in_*        - decoded op from the decoder (valid/ready)
//                ex_*        - head op towards execute (valid/ready)
//                long_done   - divider/sqrt completion pulse
//                illegal_*   - one-cycle report of a dropped illegal op
//                occupancy   - entries currently buffered
//  Config      : `define FPU_DISPATCH_PERF_EN adds saturating counters
//                perf_full_stall, perf_long_stall, perf_illegal.
//  Note        : FLEN must equal fpu_types_pkg::c_FLEN (entry operand width).
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_dispatch_stage
  import fpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FLEN  = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_select,
  input  logic [4:0]             in_op,
  input  logic [2:0]             in_rm,
  input  logic [FLEN-1:0]        in_rs1,
  input  logic [FLEN-1:0]        in_rs2,
  input  logic [FLEN-1:0]        in_rs3,
  input  logic [4:0]             in_rd,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [2:0]             ex_select,
  output logic [4:0]             ex_op,
  output logic [2:0]             ex_rm,
  output logic [FLEN-1:0]        ex_rs1,
  output logic [FLEN-1:0]        ex_rs2,
  output logic [FLEN-1:0]        ex_rs3,
  output logic [4:0]             ex_rd,
  input  logic                   long_done,
  output logic                   illegal_valid,
  output logic [4:0]             illegal_rd,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef FPU_DISPATCH_PERF_EN
  ,
  output logic [31:0]            perf_full_stall,
  output logic [31:0]            perf_long_stall,
  output logic [15:0]            perf_illegal
`endif
);

  dispatch_state_t     r_state;
  fpu_dispatch_entry_t w_in_entry;
  fpu_dispatch_entry_t w_head;
  logic                w_empty;
  logic                w_full;
  logic                w_accept;
  logic                w_legal;
  logic                w_push;
  logic                w_pop;
  logic                w_illegal_drop;
  logic                r_illegal_valid;
  logic [4:0]          r_illegal_rd;

  // Ready depends only on registered occupancy: a same-cycle pop does not
  // open a slot, keeping ex_ready off the in_ready path.
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_legal  = is_legal_fp_op(in_select, in_op);

  // Flush discards anything accepted in the same cycle, legal or not.
  assign w_push         = w_accept &&  w_legal && !flush;
  assign w_illegal_drop = w_accept && !w_legal && !flush;

  assign ex_valid = !w_empty && (r_state == IDLE);
  assign w_pop    = ex_valid && ex_ready && !flush;

  assign w_in_entry = '{select: in_select, op: in_op, rm: in_rm,
                        rs1: in_rs1, rs2: in_rs2, rs3: in_rs3, rd: in_rd};

  fpu_dispatch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (fpu_dispatch_entry_t)
  ) u_fifo (
    .CLK         (CLK),
    .nRST        (nRST),
    .i_flush     (flush),
    .i_push      (w_push),
    .i_push_data (w_in_entry),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_count     (occupancy),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign ex_select = w_head.select;
  assign ex_op     = w_head.op;
  assign ex_rm     = w_head.rm;
  assign ex_rs1    = w_head.rs1;
  assign ex_rs2    = w_head.rs2;
  assign ex_rs3    = w_head.rs3;
  assign ex_rd     = w_head.rd;

  // Issue FSM: a long op blocks issue until its completion pulse.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:      if (w_pop && is_long_fp_op(w_head.select, w_head.op)) r_state <= WAIT_LONG;
        WAIT_LONG: if (long_done) r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_illegal_valid <= 1'b0;
      r_illegal_rd    <= '0;
    end else begin
      r_illegal_valid <= w_illegal_drop;
      if (w_illegal_drop) r_illegal_rd <= in_rd;
    end
  end

  assign illegal_valid = r_illegal_valid;
  assign illegal_rd    = r_illegal_rd;

`ifdef FPU_DISPATCH_PERF_EN
  logic [31:0] r_perf_full_stall;
  logic [31:0] r_perf_long_stall;
  logic [15:0] r_perf_illegal;

  // Saturating event counters; only reset clears them, flush does not.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_perf_full_stall <= '0;
      r_perf_long_stall <= '0;
      r_perf_illegal    <= '0;
    end else begin
      if (in_valid && !in_ready && (r_perf_full_stall != '1))
        r_perf_full_stall <= r_perf_full_stall + 1'b1;
      if ((r_state == WAIT_LONG) && !w_empty && (r_perf_long_stall != '1))
        r_perf_long_stall <= r_perf_long_stall + 1'b1;
      if (w_illegal_drop && (r_perf_illegal != '1))
        r_perf_illegal <= r_perf_illegal + 1'b1;
    end
  end

  assign perf_full_stall = r_perf_full_stall;
  assign perf_long_stall = r_perf_long_stall;
  assign perf_illegal    = r_perf_illegal;
`endif

endmodule
`default_nettype wire
